// File: rtl/sub_32_serial_pkg.sv
// rtl/sub_32_serial_pkg.sv - shared state encoding and sizing for the serial subtractor
package sub_32_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_slice_4.sv
// rtl/sub_slice_4.sv - combinational 4-bit carry-lookahead adder slice
// Exposes the carry into bit 3 so the caller can derive signed overflow.
module sub_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] nb,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c_msb
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & nb;
  assign p = a ^ nb;

  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ {c3, c2, c1, c_in};
  assign c_msb = c3;

endmodule

// File: rtl/sub_32_serial.sv
// rtl/sub_32_serial.sv - multi-cycle subtractor d = a - b - borrow_in, one slice per cycle
// Computes a + ~b + ~borrow_in; the result register is only published on the last slice.
module sub_32_serial #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = sub_32_serial_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             overflow
);

  import sub_32_serial_pkg::*;

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = clog2(N);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             carry_q, carry_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;

  logic [SLICE_W-1:0] s;
  logic               c_out;
  logic               c_msb;

  sub_slice_4 u_slice (
    .a     (a_q[SLICE_W-1:0]),
    .nb    (b_q[SLICE_W-1:0]),
    .c_in  (carry_q),
    .s     (s),
    .c_out (c_out),
    .c_msb (c_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    carry_d = carry_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = ~b;
          carry_d = ~borrow_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        r_d     = {s, r_q[WIDTH-1:SLICE_W]};
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = c_out;
        if (cnt_q == CW'(N - 1)) begin
          // The final slice holds the MSB, so its carries give the flags.
          d_d     = r_d;
          ov_d    = c_msb ^ c_out;
          bo_d    = ~c_out;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      carry_q <= 1'b0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      carry_q <= carry_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign d          = d_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule

// File: tb/tb_sub_32_serial.sv
// tb/tb_sub_32_serial.sv - directed and random checks of sub_32_serial against an arithmetic model
module tb_sub_32_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        borrow_out;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sub_32_serial dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {overflow, borrow_out, d} from plain unsigned and signed arithmetic
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic bin);
    logic [32:0] u;
    longint      sx, sy, sd;
    logic        ov;
    u  = {1'b0, x} - {1'b0, y} - {32'd0, bin};
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy - longint'(bin);
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {ov, u[32], u[31:0]};
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic bin);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = x; b = y; borrow_in = bin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; borrow_in = 1'($urandom);
  endtask

  task automatic wait_done();
    int lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd8);
  endtask

  task automatic finish_op(input logic [33:0] exp, input int hold);
    for (int i = 0; i <= hold; i++) begin
      check("d", d, exp[31:0]);
      check("borrow_out", {31'd0, borrow_out}, {31'd0, exp[32]});
      check("overflow", {31'd0, overflow}, {31'd0, exp[33]});
      check("out_valid_held", {31'd0, out_valid}, 32'd1);
      if (i < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic bin, input int hold);
    start_op(x, y, bin);
    wait_done();
    finish_op(model(x, y, bin), hold);
  endtask

  initial begin
    logic [33:0] exp1, exp2;
    logic [31:0] x2, y2;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_borrow_out", {31'd0, borrow_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd5, 32'd3, 1'b0, 0);
    check("tp1_d_const", d, 32'h0000_0002);
    run_op(32'd0, 32'd1, 1'b0, 0);
    check("tp2_d_const", d, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1);
    check("tp3a_ov_const", {31'd0, overflow}, 32'd1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("tp3b_d_const", d, 32'h8000_0000);
    run_op(32'd10, 32'd3, 1'b1, 0);
    check("tp4a_d_const", d, 32'd6);
    run_op(32'd3, 32'd3, 1'b1, 0);
    check("tp4b_bo_const", {31'd0, borrow_out}, 32'd1);

    // backpressure: result held, second request refused until DONE exits
    exp1 = model(32'h1234_5678, 32'h0235_9ABC, 1'b0);
    start_op(32'h1234_5678, 32'h0235_9ABC, 1'b0);
    wait_done();
    x2 = $urandom; y2 = $urandom;
    exp2 = model(x2, y2, 1'b1);
    a = x2; b = y2; borrow_in = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_d", d, exp1[31:0]);
      check("bp_borrow_out", {31'd0, borrow_out}, {31'd0, exp1[32]});
      check("bp_overflow", {31'd0, overflow}, {31'd0, exp1[33]});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; borrow_in = 1'b0;
    check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
    wait_done();
    finish_op(exp2, 0);

    // reset while the counter sits at slice 4
    start_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_d", d, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    run_op(32'd100, 32'd1, 1'b0, 0);
    check("post_rst_d_const", d, 32'd99);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = (i % 5 == 0) ? rx : $urandom;
      run_op(rx, ry, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sub_32_serial.md
Name: sub_32_serial

Overview:
- Multi-cycle 32-bit subtractor with borrow: d = a - b - borrow_in.
- Computes two's-complement style as a + ~b + carry, one 4-bit lookahead slice per cycle.
- Sits beside the combinational 32-bit adder. Provides the subtract direction for compare/decrement paths where area matters more than latency.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE_W.
- SLICE_W, 4, bits processed per cycle; the number of slices is N = WIDTH/SLICE_W (8 at default).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  incoming borrow
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference
- borrow_out  output  1  1 iff unsigned a < b + borrow_in
- overflow  output  1  signed overflow of a - b - borrow_in

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, d=0, borrow_out=0, overflow=0; internal slice counter and carry = 0.
- States are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a into shift register A and ~b into shift register B; set carry = ~borrow_in; set counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the 4-bit slice adds the low SLICE_W bits of A and B plus carry.
  - The sum shifts into the top of the result register. A and B shift right by SLICE_W. carry takes the slice carry-out.
  - On the last slice (counter==N-1):
    - Record the carry into the MSB and the carry out of the MSB.
    - overflow = c_into_msb XOR c_out_msb.
    - borrow_out = ~c_out_msb.
    - Go to DONE.
  - Otherwise counter increments.
- DONE:
  - out_valid=1; d, borrow_out and overflow are stable and held.
  - On out_ready: out_valid drops the next cycle; go to IDLE.
- Latency: accept edge at cycle 0, out_valid high after cycle N (8 edges later at default). Throughput is one op per N+2 cycles minimum.
- Operand inputs and borrow_in are ignored outside the IDLE accept cycle; changes during RUN have no effect.
- in_valid asserted while in RUN or DONE is not accepted. in_ready is low, so the producer must hold.
- DONE with out_ready=0: hold indefinitely with all outputs unchanged (backpressure).
- out_ready while not out_valid: ignored.
- Output side: d/borrow_out/overflow keep the last result while in IDLE and RUN until overwritten at the end of the next RUN. Consumers use them only with out_valid.
- Reset mid-RUN or mid-DONE: immediate return to the reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package constants:
  - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - SLICE_W
  - the slice-count width function clog2(WIDTH/SLICE_W)
- One sub-module: sub_slice_4.
  - Combinational 4-bit lookahead slice.
  - Inputs: a[3:0], nb[3:0], c_in.
  - Outputs: s[3:0], c_out, c_msb (carry into bit 3).
  - Built from the existing gate primitives.
  - The FSM, counter and shift registers stay in sub_32_serial.

Test Plan:
1. a=5, b=3, borrow_in=0 -> after 8 cycles out_valid=1, d=0x00000002, borrow_out=0, overflow=0.
2. a=0, b=1, borrow_in=0 -> d=0xFFFFFFFF, borrow_out=1, overflow=0.
3. a=0x80000000, b=1 -> d=0x7FFFFFFF, borrow_out=0, overflow=1. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> d=0x80000000, borrow_out=1, overflow=1.
4. a=10, b=3, borrow_in=1 -> d=6, borrow_out=0. Then a=3, b=3, borrow_in=1 -> d=0xFFFFFFFF, borrow_out=1.
5. Backpressure: complete an op with out_ready=0 for 5 cycles -> out_valid, d and flags stable, in_ready=0 throughout, and a second in_valid is not accepted. Raise out_ready -> IDLE next cycle, then the second op is accepted.
6. Assert reset at RUN slice 4 -> out_valid=0, in_ready=1, d=0 immediately. The next op (a=100, b=1) returns d=99 with correct latency.
